// File: rtl/ins_pkg.sv
// Shared pipeline constants and types for the decode/execute/write-back stages.
package ins_pkg;

  localparam int XLEN    = 32;
  localparam int REG_CNT = 32;
  localparam int REG_IDX_W = $clog2(REG_CNT);
  localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

  // One store-buffer entry: byte address and data word travel together.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] val;
  } sb_entry_t;

  // x0 is hardwired to zero: writes are discarded and reads return zero.
  function automatic logic is_x0(input logic [REG_IDX_W-1:0] idx);
    return idx == REG_X0;
  endfunction

endpackage

// File: rtl/ins_wb_sb.sv
// Store buffer: small FIFO between write-back and data memory.
// Head is presented with a valid/ready handshake; a push into a full buffer
// is still accepted when the head drains on the same edge, otherwise it is
// dropped and a sticky overflow flag is raised. Entry storage is not reset:
// the head output is masked to zero whenever the buffer is empty.
module ins_wb_sb #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_req,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop_ready,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf_q;
  logic             do_push;
  logic             do_pop;

  // Full and valid come only from the registered count, never from inputs.
  assign full       = (cnt == CW'(DEPTH));
  assign head_valid = (cnt != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;
  assign count      = cnt;
  assign ovf        = ovf_q;

  // A drain on this edge frees a slot, so a push into a full buffer still fits.
  assign do_pop  = head_valid && pop_ready;
  assign do_push = push_req && (!full || do_pop);

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (push_req && full && !do_pop) ovf_q <= 1'b1;
    end
  end

  // Entry storage: written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ins_wb.sv
// Write-back stage: 32-entry integer register file with same-cycle write
// bypass on both read ports, plus a store buffer draining to data memory.
// Execute drives its requests on the falling edge; everything is captured
// on the rising edge. While reset is asserted all requests are ignored.
module ins_wb
  import ins_pkg::*;
#(
  parameter int              SB_DEPTH    = 4,
  parameter logic [XLEN-1:0] REG_RST_VAL = 32'd0
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        reg_w_op,
  input  logic [4:0]                  reg_w_reg_idx,
  input  logic [XLEN-1:0]             reg_w_reg_val,
  input  logic                        mem_w_op,
  input  logic [XLEN-1:0]             mem_w_mem_addr,
  input  logic [XLEN-1:0]             mem_w_mem_val,
  input  logic [4:0]                  rd_rs1,
  output logic [XLEN-1:0]             rd_rs1_val,
  input  logic [4:0]                  rd_rs2,
  output logic [XLEN-1:0]             rd_rs2_val,
  output logic                        dmem_w_valid,
  input  logic                        dmem_w_ready,
  output logic [XLEN-1:0]             dmem_w_addr,
  output logic [XLEN-1:0]             dmem_w_val,
  output logic                        sb_full,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        sb_ovf
);

  logic [XLEN-1:0] regs [REG_CNT];
  logic            wr_en;
  sb_entry_t       push_entry;
  sb_entry_t       head_entry;

  // A write is live only out of reset and never targets x0.
  assign wr_en = sys_rst_n && reg_w_op && !is_x0(reg_w_reg_idx);

  // Register file; entry 0 is never written and never read back.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= REG_RST_VAL;
    end else if (wr_en) begin
      regs[reg_w_reg_idx] <= reg_w_reg_val;
    end
  end

  // Read ports: x0 reads zero, a same-cycle write to the index is forwarded.
  always_comb begin
    rd_rs1_val = regs[rd_rs1];
    rd_rs2_val = regs[rd_rs2];
    if (wr_en && (rd_rs1 == reg_w_reg_idx)) rd_rs1_val = reg_w_reg_val;
    if (wr_en && (rd_rs2 == reg_w_reg_idx)) rd_rs2_val = reg_w_reg_val;
    if (is_x0(rd_rs1)) rd_rs1_val = '0;
    if (is_x0(rd_rs2)) rd_rs2_val = '0;
  end

  assign push_entry.addr = mem_w_mem_addr;
  assign push_entry.val  = mem_w_mem_val;

  ins_wb_sb #(
    .DEPTH (SB_DEPTH),
    .WIDTH ($bits(sb_entry_t))
  ) u_sb (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .push_req   (mem_w_op),
    .push_data  (push_entry),
    .pop_ready  (dmem_w_ready),
    .head_valid (dmem_w_valid),
    .head_data  (head_entry),
    .count      (sb_count),
    .full       (sb_full),
    .ovf        (sb_ovf)
  );

  assign dmem_w_addr = head_entry.addr;
  assign dmem_w_val  = head_entry.val;

endmodule

// File: doc/ins_wb.md
INS_WB -- requirements
Module: ins_wb

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 4, store-buffer entry count (power of two, 2..16).
REQ-002 SHALL have parameter REG_RST_VAL, default 32'd0, reset value of x1..x31.
REQ-003 SHALL have port sys_clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port reg_w_op  in  1  register write request from execute stage.
REQ-006 SHALL have port reg_w_reg_idx  in  5  destination register index.
REQ-007 SHALL have port reg_w_reg_val  in  32  destination register value.
REQ-008 SHALL have port mem_w_op  in  1  store request from execute stage.
REQ-009 SHALL have port mem_w_mem_addr  in  32  store byte address.
REQ-010 SHALL have port mem_w_mem_val  in  32  store data word.
REQ-011 SHALL have port rd_rs1  in  5  read port 1 index.
REQ-012 SHALL have port rd_rs1_val  out  32  read port 1 data.
REQ-013 SHALL have port rd_rs2  in  5  read port 2 index.
REQ-014 SHALL have port rd_rs2_val  out  32  read port 2 data.
REQ-015 SHALL have port dmem_w_valid  out  1  store buffer head valid toward data memory.
REQ-016 SHALL have port dmem_w_ready  in  1  data memory accepts head.
REQ-017 SHALL have port dmem_w_addr  out  32  head address.
REQ-018 SHALL have port dmem_w_val  out  32  head data.
REQ-019 SHALL have port sb_full  out  1  store buffer full; upstream holds stores.
REQ-020 SHALL have port sb_count  out  $clog2(SB_DEPTH)+1  occupied entries.
REQ-021 SHALL have port sb_ovf  out  1  sticky overflow flag.

Function
REQ-022 SHALL sample all execute-stage inputs on posedge sys_clk (execute drives them on negedge; half-cycle setup).
REQ-023 SHALL write reg_w_reg_val into register reg_w_reg_idx at posedge when reg_w_op=1 and idx!=0; writes to x0 ignored.
REQ-024 SHALL return 32'd0 combinationally on a read port whose index is 0, regardless of pending writes.
REQ-025 SHALL bypass: read port with index==reg_w_reg_idx!=0 while reg_w_op=1 returns reg_w_reg_val same cycle; else stored value.
REQ-026 SHALL push {addr,val} into store buffer at posedge when mem_w_op=1 and (sb_full=0 or pop occurs same edge).
REQ-027 SHALL pop head at posedge when dmem_w_valid=1 and dmem_w_ready=1.
REQ-028 SHALL drive dmem_w_valid=(sb_count!=0); head addr/val stable while valid=1 and ready=0.
REQ-029 SHALL, on simultaneous push and pop, keep sb_count unchanged and preserve FIFO order, including when full or count=1.
REQ-030 SHALL drop a push when full with no pop, and set sb_ovf=1 until reset; sb_count unchanged.
REQ-031 SHALL give one-cycle latency: store pushed at edge N to empty buffer appears on dmem_w_valid/addr/val after edge N.
REQ-032 SHALL wrap read/write pointers modulo SB_DEPTH; sb_full=(sb_count==SB_DEPTH), registered-derived, no combinational path from inputs.
REQ-033 SHALL treat reg_w_op and mem_w_op independently; both may be asserted same cycle.

Reset
REQ-034 SHALL on sys_rst_n=0 immediately set x1..x31=REG_RST_VAL, pointers=0, sb_count=0, sb_full=0, dmem_w_valid=0, sb_ovf=0.
REQ-035 SHALL discard buffered stores on reset mid-drain; dmem_w_addr/val=0 while empty.
REQ-036 SHALL ignore all requests while sys_rst_n=0; first write accepted at first posedge after deassertion.

Structure
REQ-037 SHALL take XLEN=32, REG_CNT=32, REG_X0=5'd0 from shared package ins_pkg, also used by decode/execute.
REQ-038 SHALL implement the store buffer as sub-module ins_wb_sb (parameterised FIFO, valid/ready pop); register file inline.

Verification
REQ-039 SHALL test: reg_w_op=1, idx=5, val=32'hDEADBEEF, rd_rs1=5 same cycle -> rd_rs1_val=32'hDEADBEEF, and persists after edge.
REQ-040 SHALL test: reg_w_op=1, idx=0, val=32'h1234 -> rd_rs2=0 reads 32'd0 same cycle and after.
REQ-041 SHALL test: 4 stores (addr 0x10..0x1C), dmem_w_ready=0 -> sb_full=1, sb_count=4; raise ready -> drained in order, one per cycle.
REQ-042 SHALL test: full buffer, push with ready=1 same cycle -> accepted, sb_count=4, sb_ovf=0; push with ready=0 -> dropped, sb_ovf=1.
REQ-043 SHALL test: 2 stores buffered, sys_rst_n pulsed low mid-cycle -> dmem_w_valid=0, sb_count=0 immediately, registers=REG_RST_VAL.
